mult_div_unit: RTL and testbench

//  Multicycle multiply/divide unit (HI/LO) next to the ALU in the multicycle MIPS datapath.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_sign_conv.sv | 12 +
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT,
        MDU_MULTU,
        MDU_DIV,
        MDU_DIVU
    } mdu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DZ
    } mdu_state_t;

endpackage

// File: rtl/mdu_sign_conv.sv
// Conditional two's-complement negate; with negate = sign bit it acts as abs().
module mdu_sign_conv #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (W'(0) - value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// operands held as magnitudes and sign-corrected in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [2:0]       dbg_state
);

    // Handshake: start is accepted only while busy=0; busy stays high from the
    // accepting edge until the result edge; done pulses for one cycle with HI/LO valid.
    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t         state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               div_q, div_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic               is_signed, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag, quot_fixed, rem_fixed;
    logic [2*WIDTH-1:0] prod_fixed, mul_next, div_next;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign is_div    = (op == MDU_DIV) || (op == MDU_DIVU);

    mdu_sign_conv #(.W(WIDTH)) u_abs_a (
        .value(operand_a), .negate(is_signed & operand_a[WIDTH-1]), .result(a_mag));
    mdu_sign_conv #(.W(WIDTH)) u_abs_b (
        .value(operand_b), .negate(is_signed & operand_b[WIDTH-1]), .result(b_mag));
    mdu_sign_conv #(.W(2*WIDTH)) u_fix_prod (
        .value(acc_q), .negate(neg_lo_q), .result(prod_fixed));
    mdu_sign_conv #(.W(WIDTH)) u_fix_quot (
        .value(acc_q[WIDTH-1:0]), .negate(neg_lo_q), .result(quot_fixed));
    mdu_sign_conv #(.W(WIDTH)) u_fix_rem (
        .value(acc_q[2*WIDTH-1:WIDTH]), .negate(neg_hi_q), .result(rem_fixed));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left; quotient bits enter at bit 0.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, mcand_q};
    assign div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div_d    = div_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                if (start) begin
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    div_d    = is_div;
                    neg_lo_d = is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    neg_hi_d = is_signed & operand_a[WIDTH-1];
                    if (!is_div) begin
                        state_d = MUL;
                        mcand_d = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                    end else if (operand_b == '0) begin
                        // Raw dividend is kept so DZ can hand it back in HI.
                        state_d = DZ;
                        mcand_d = operand_a;
                    end else begin
                        state_d = DIV;
                        mcand_d = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                    end
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (div_q) begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end else begin
                    {hi_d, lo_d} = prod_fixed;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DZ: begin
                hi_d    = mcand_q;
                lo_d    = '1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div_q    <= div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, busy/done, mthi/mtlo, reset abort.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start, hi_wr, lo_wr;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, wr_data, hi, lo;
    logic        busy, done, div_by_zero;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op at the next negedge and wait (bounded) for done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz,
                          input int exp_lat, input bit chk_pulse);
        int lat;
        bit got;
        @(negedge clock);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        check($sformatf("%s busy_after_start", tag), 32'(busy), 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (done) got = 1'b1;
        end
        check($sformatf("%s latency", tag), lat, exp_lat);
        check($sformatf("%s hi", tag), hi, exp_hi);
        check($sformatf("%s lo", tag), lo, exp_lo);
        check($sformatf("%s div_by_zero", tag), 32'(div_by_zero), 32'(exp_dz));
        check($sformatf("%s busy_at_done", tag), 32'(busy), 32'd0);
        if (chk_pulse) begin
            @(posedge clock); #1;
            check($sformatf("%s done_one_cycle", tag), 32'(done), 32'd0);
        end
    endtask

    initial begin
        int lat;
        int dones;
        logic [31:0] hi_s, lo_s;

        reset = 1'b1; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        op = 2'b00; operand_a = '0; operand_b = '0; wr_data = '0;
        #12;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dz", 32'(div_by_zero), 32'd0);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        @(negedge clock);
        reset = 1'b0;

        run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b1);
        run_op("mult_m3x5", MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 1'b0);
        // Next op is launched inside the previous done cycle.
        run_op("mult_7x6", MDU_MULT, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 33, 1'b0);
        run_op("div_m7d2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
        run_op("divu_big", MDU_DIVU, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 1'b0, 33, 1'b0);
        run_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b1, 1, 1'b1);

        // Signed overflow divide with a second start pulsed mid-op.
        @(negedge clock);
        op = MDU_DIV; operand_a = 32'h80000000; operand_b = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        dones = 0; lat = 0; hi_s = 'x; lo_s = 'x;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clock); #1;
            if (n == 5) start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) begin lat = n; hi_s = hi; lo_s = lo; end
            end
            if (n == 4) begin
                @(negedge clock);
                op = MDU_MULTU; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
            end
        end
        check("div_ovf done_count", dones, 32'd1);
        check("div_ovf latency", lat, 32'd33);
        check("div_ovf lo", lo_s, 32'h80000000);
        check("div_ovf hi", hi_s, 32'h0);

        // Reset in cycle 10 of a mult aborts it.
        @(negedge clock);
        op = MDU_MULT; operand_a = 32'h12345; operand_b = 32'h10; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("rst_mid hi", hi, 32'h0);
        check("rst_mid lo", lo, 32'h0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid state", 32'(dbg_state), 32'(IDLE));
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        check("rst_mid no_done", dones, 32'd0);
        check("rst_mid lo_kept", lo, 32'h0);

        // mthi/mtlo together while idle.
        @(negedge clock);
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hCAFE;
        @(posedge clock); #1;
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthilo_idle hi", hi, 32'hCAFE);
        check("mthilo_idle lo", lo, 32'hCAFE);

        // mthi on the accepting edge applies; writes while busy are dropped; result overwrites.
        @(negedge clock);
        op = MDU_MULT; operand_a = 32'd7; operand_b = 32'd6; start = 1'b1;
        hi_wr = 1'b1; wr_data = 32'hBEEF;
        @(posedge clock); #1;
        start = 1'b0; hi_wr = 1'b0;
        check("mthi_start hi", hi, 32'hBEEF);
        check("mthi_start lo", lo, 32'hCAFE);
        @(negedge clock);
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h1234;
        @(posedge clock); #1;
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthi_busy hi", hi, 32'hBEEF);
        check("mtlo_busy lo", lo, 32'hCAFE);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        check("mthi_over latency", lat, 32'd33);
        check("mthi_over hi", hi, 32'h0);
        check("mthi_over lo", lo, 32'h2A);

        @(negedge clock);
        hi_wr = 1'b1; wr_data = 32'h1234;
        @(posedge clock); #1;
        hi_wr = 1'b0;
        check("mthi_idle hi", hi, 32'h1234);
        check("mthi_idle lo", lo, 32'h2A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
